// File: rtl/clamped_index_pipe.sv
// Bounds-safe table lookup: out = arr[min(sel + OFFSET, DEPTH-1)] through a STAGES-deep valid/ready pipe.
// Optional macro CLAMPED_INDEX_OOB_COUNT_EN adds a saturating count of delivered clamped transactions.
module clamped_index_pipe #(
  parameter int unsigned ELEM_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned OFFSET = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef CLAMPED_INDEX_OOB_COUNT_EN
  output logic [15:0]             oob_count,
`endif
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [ELEM_W*DEPTH-1:0] arr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ELEM_W-1:0]       out,
  output logic                    out_clamped
);

  localparam int unsigned OW = $clog2(OFFSET + 1);
  localparam int unsigned IW = ((SEL_W > OW) ? SEL_W : OW) + 1;
  localparam int unsigned CW = (IW > 32) ? IW : 32;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IW-1:0]     w_idx;
  logic              w_clamp;
  logic [AW-1:0]     w_sel_idx;
  logic [ELEM_W-1:0] w_elem;
  logic [STAGES-1:0] w_adv;

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_clamp;
  logic [ELEM_W-1:0] r_data [STAGES];

  // Compare at >=32 bits so DEPTH-1 is never truncated to the index width.
  always_comb begin
    w_idx     = IW'(sel) + IW'(OFFSET);
    w_clamp   = CW'(w_idx) > CW'(DEPTH - 1);
    w_sel_idx = w_clamp ? AW'(DEPTH - 1) : w_idx[AW-1:0];
    w_elem    = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (AW'(k) == w_sel_idx) w_elem = arr[ELEM_W*k +: ELEM_W];
    end
  end

  // A stage may advance when the output drains or any stage from it onward is empty.
  always_comb begin
    logic v_full;
    v_full = 1'b1;
    w_adv  = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      v_full                = v_full & r_valid[STAGES-1-k];
      w_adv[STAGES-1-k]     = out_ready | ~v_full;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_clamp <= '0;
      for (int unsigned k = 0; k < STAGES; k++) r_data[k] <= '0;
    end else begin
      if (w_adv[0]) begin
        r_valid[0] <= in_valid;
        if (in_valid) begin
          r_data[0]  <= w_elem;
          r_clamp[0] <= w_clamp;
        end
      end
      for (int unsigned k = 1; k < STAGES; k++) begin
        if (w_adv[k]) begin
          r_valid[k] <= r_valid[k-1];
          if (r_valid[k-1]) begin
            r_data[k]  <= r_data[k-1];
            r_clamp[k] <= r_clamp[k-1];
          end
        end
      end
    end
  end

  assign in_ready    = w_adv[0];
  assign out_valid   = r_valid[STAGES-1];
  assign out         = r_data[STAGES-1];
  assign out_clamped = r_clamp[STAGES-1];

`ifdef CLAMPED_INDEX_OOB_COUNT_EN
  logic [15:0] r_oob;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_oob <= '0;
    end else if (out_valid && out_ready && out_clamped && (r_oob != 16'hFFFF)) begin
      r_oob <= r_oob + 16'd1;
    end
  end

  assign oob_count = r_oob;
`endif

endmodule

// File: tb/tb_clamped_index_pipe.sv
// Directed bench for clamped_index_pipe: scoreboard on delivered outputs plus a DEPTH=8/STAGES=1 instance.
module tb_clamped_index_pipe;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, out_clamped;
  logic [1:0]   sel;
  logic [127:0] arr;
  logic [31:0]  out;

  logic         in_valid8, in_ready8, out_valid8, out_ready8, out_clamped8;
  logic [2:0]   sel8;
  logic [255:0] arr8;
  logic [31:0]  out8;

`ifdef CLAMPED_INDEX_OOB_COUNT_EN
  logic [15:0]  oob_count, oob_count8;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        clamp;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_exp;
  int   checks  = 0;
  int   errors  = 0;
  int   exp_oob = 0;

  always #5 clk = ~clk;

  clamped_index_pipe #(.ELEM_W(32), .DEPTH(4), .SEL_W(2), .OFFSET(1), .STAGES(2)) u_dut (
    .clk(clk), .rst(rst),
`ifdef CLAMPED_INDEX_OOB_COUNT_EN
    .oob_count(oob_count),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .sel(sel), .arr(arr),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_clamped(out_clamped)
  );

  clamped_index_pipe #(.ELEM_W(32), .DEPTH(8), .SEL_W(3), .OFFSET(6), .STAGES(1)) u_dut8 (
    .clk(clk), .rst(rst),
`ifdef CLAMPED_INDEX_OOB_COUNT_EN
    .oob_count(oob_count8),
`endif
    .in_valid(in_valid8), .in_ready(in_ready8), .sel(sel8), .arr(arr8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out(out8), .out_clamped(out_clamped8)
  );

  // Output monitor: every handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_output got %h clamped=%b, required no output", out, out_clamped);
      end
      if (sb_q.size() != 0) begin
        m_exp = sb_q.pop_front();
        checks++;
        assert ({out, out_clamped} === {m_exp.data, m_exp.clamp}) else begin
          errors++;
          $error("FAIL out_payload got %h/%b required %h/%b", out, out_clamped, m_exp.data, m_exp.clamp);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h required %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one transaction and returns #1 after the edge that accepts it.
  task automatic drive(input logic [1:0] s, input logic [31:0] d, input logic c, input bit push);
    bit   ok;
    exp_t e;
    ok       = 1'b0;
    in_valid = 1'b1;
    sel      = s;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        if (push) begin
          e.data  = d;
          e.clamp = c;
          sb_q.push_back(e);
          if (c) exp_oob++;
        end
      end
      tick();
    end
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL accept_timeout got in_ready=0 for 50 cycles required acceptance of sel=%0d", s);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) tick();
    chk("drain", sb_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; sel = '0; out_ready = 1'b1;
    arr = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    in_valid8 = 1'b0; sel8 = '0; out_ready8 = 1'b1;
    for (int k = 0; k < 8; k++) arr8[32*k +: 32] = 32'h70000000 + k;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out", out, 0);
    chk("reset_out_clamped", out_clamped, 0);
    chk("reset_in_ready", in_ready, 1);

    // Basic indexing, two-cycle latency
    drive(2'd0, 32'hBBBB0001, 1'b0, 1'b1);
    chk("latency_not_early", out_valid, 0);
    drive(2'd1, 32'hCCCC0002, 1'b0, 1'b1);
    chk("latency_two", out_valid, 1);
    drive(2'd2, 32'hDDDD0003, 1'b0, 1'b1);
    in_valid = 1'b0;
    wait_drain();

    // Clamp at the top of the table
    drive(2'd3, 32'hDDDD0003, 1'b1, 1'b1);
    in_valid = 1'b0;
    chk("clamp_not_early", out_valid, 0);
    tick();
    chk("clamp_valid", out_valid, 1);
    chk("clamp_flag", out_clamped, 1);
    wait_drain();

    // Backpressure: two accepts fill the pipe, third waits
    out_ready = 1'b0;
    drive(2'd0, 32'hBBBB0001, 1'b0, 1'b1);
    drive(2'd1, 32'hCCCC0002, 1'b0, 1'b1);
    in_valid = 1'b1; sel = 2'd2;
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_out_hold", out, 32'hBBBB0001);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    drive(2'd2, 32'hDDDD0003, 1'b0, 1'b1);
    in_valid = 1'b0;
    wait_drain();

    // Reset with two transactions in flight; nothing may emerge afterwards
    out_ready = 1'b0;
    drive(2'd0, 32'hBBBB0001, 1'b0, 1'b0);
    drive(2'd3, 32'hDDDD0003, 1'b1, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_oob = 0;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_out", out, 0);
    chk("midreset_out_clamped", out_clamped, 0);
    chk("midreset_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (5) tick();

    // Clamped/unclamped mix with a long stall on a clamped result
    drive(2'd3, 32'hDDDD0003, 1'b1, 1'b1);
    drive(2'd0, 32'hBBBB0001, 1'b0, 1'b1);
    in_valid = 1'b0;
    wait_drain();
    out_ready = 1'b0;
    drive(2'd3, 32'hDDDD0003, 1'b1, 1'b1);
    in_valid = 1'b0;
    repeat (5) tick();
    chk("stall_clamped_hold", {out[31:1], out_clamped}, {31'h6EEE8001, 1'b1});
    out_ready = 1'b1;
    drive(2'd1, 32'hCCCC0002, 1'b0, 1'b1);
    drive(2'd3, 32'hDDDD0003, 1'b1, 1'b1);
    in_valid = 1'b0;
    wait_drain();
    repeat (2) tick();
`ifdef CLAMPED_INDEX_OOB_COUNT_EN
    chk("oob_count", oob_count, exp_oob);
`endif

    // DEPTH=8, OFFSET=6, STAGES=1 instance
    in_valid8 = 1'b1; sel8 = 3'd1;
    tick();
    chk("p8_sel1_valid", out_valid8, 1);
    chk("p8_sel1_out", out8, 32'h70000007);
    chk("p8_sel1_clamped", out_clamped8, 0);
    sel8 = 3'd2;
    tick();
    chk("p8_sel2_out", out8, 32'h70000007);
    chk("p8_sel2_clamped", out_clamped8, 1);
    sel8 = 3'd0;
    tick();
    chk("p8_sel0_out", out8, 32'h70000006);
    chk("p8_sel0_clamped", out_clamped8, 0);
    in_valid8 = 1'b0;
    tick();
    chk("p8_idle_valid", out_valid8, 0);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clamped_index_pipe.md
Name: clamped_index_pipe

Overview:
- Parametrised, pipelined successor to the single-stage enum-indexed array read.
- Captures an array operand and a selector, computes `sel + OFFSET`, and clamps that index to `DEPTH-1` instead of trapping.
- Returns the selected element through a STAGES-deep valid/ready pipeline with backpressure.
- Sits between DSLX-generated datapath stages wherever a bounds-safe table lookup is needed.

Parameters:
- ELEM_W, 32: element width in bits.
- DEPTH, 4: number of array elements (>=1).
- SEL_W, 2: selector width in bits.
- OFFSET, 1: unsigned constant added to sel before clamping (>=0).
- STAGES, 2: pipeline depth in register stages (>=1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input transaction present.
- in_ready  output  1  block accepts the input this cycle.
- sel  input  SEL_W  unsigned selector.
- arr  input  ELEM_W*DEPTH  flattened array; element k is `arr[ELEM_W*k +: ELEM_W]`.
- out_valid  output  1  output transaction present.
- out_ready  input  1  downstream accepts the output this cycle.
- out  output  ELEM_W  selected element.
- out_clamped  output  1  index was clamped for this transaction.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - all stage valid bits = 0, so out_valid = 0;
  - out = 0;
  - out_clamped = 0;
  - in_ready = 1 in the first cycle after reset deasserts.
- Reset mid-operation: all in-flight transactions are discarded. No output is produced for them.
- Index arithmetic (combinational, on the input side):
  - zero-extend sel to IW = max(SEL_W, clog2(OFFSET+1)) + 1 bits, then add OFFSET. The add never overflows.
  - if idx > DEPTH-1: use DEPTH-1 and set clamped = 1. Otherwise use idx[clog2(DEPTH)-1:0] and set clamped = 0.
  - DEPTH = 1: index is always 0; clamped = (sel + OFFSET != 0).
- Capture:
  - on in_valid && in_ready, the selected element and the clamped flag load into stage 1 with valid = 1.
  - arr and sel are sampled only in the accept cycle and need not be held afterwards.
- Pipeline:
  - stages 1..STAGES each hold {valid, data[ELEM_W], clamped}.
  - out / out_valid / out_clamped come straight from stage STAGES (registered outputs, no combinational input-to-output path).
- Advance rule:
  - stage s accepts new content when it is empty or stage s+1 accepts.
  - the last stage advances when out_ready = 1.
  - in_ready = stage-1 accept condition. It depends combinationally on out_ready through the chain; that path is permitted.
  - bubbles collapse, so an empty stage fills even while downstream is stalled.
- Latency and throughput:
  - STAGES cycles from accept to out_valid when unstalled (STAGES=1: out_valid in the cycle after accept).
  - throughput is one transaction per cycle.
- Stall:
  - with out_valid = 1 and out_ready = 0, out and out_clamped hold stable.
  - no transaction is dropped or duplicated.
  - after STAGES accepted transactions under a continuous stall, in_ready = 0.
- Simultaneous events:
  - output handshake and input accept in the same cycle on a full pipe are legal. in_ready = 1 and contents shift by one.
  - rst has priority over all handshakes.
- Payload when not valid: out / out_clamped hold their last value. They are don't-care when out_valid = 0, except immediately after reset, where they are 0.

Optional Feature:
- Macro: CLAMPED_INDEX_OOB_COUNT_EN.
- Defined:
  - adds output port `oob_count`, 16 bits.
  - counts output handshakes (out_valid && out_ready) with out_clamped = 1.
  - saturates at 16'hFFFF; reset value 0.
  - counting is unaffected by stalls; each delivered transaction counts once.
- Undefined:
  - port and counter are absent.
  - all other behaviour is identical.

Test Plan (defaults: ELEM_W=32, DEPTH=4, SEL_W=2, OFFSET=1, STAGES=2):
- Setup: arr elements = {0xDDDD0003, 0xCCCC0002, 0xBBBB0001, 0xAAAA0000} for elements 3..0.
- Basic indexing, out_ready=1: sel = 0,1,2 on consecutive cycles -> out = 0xBBBB0001, 0xCCCC0002, 0xDDDD0003 in cycles 2,3,4; out_clamped = 0.
- Clamp: sel=3 (idx 4) -> out = 0xDDDD0003, out_clamped = 1, two cycles after accept.
- Backpressure: out_ready = 0 while sel = 0,1,2 are offered -> in_ready drops after 2 accepts and out holds 0xBBBB0001. Release out_ready -> 0xBBBB0001 then 0xCCCC0002, then sel=2 accepted and returns 0xDDDD0003, no loss.
- Reset mid-flight: assert rst for 1 cycle with 2 transactions in flight -> next cycle out_valid = 0, out = 0, in_ready = 1, and no stale output appears.
- Parameter sweep: DEPTH=8, SEL_W=3, OFFSET=6, STAGES=1 -> sel = 1 gives element 7, unclamped; sel = 2 gives element 7, clamped; latency 1 cycle.
- With CLAMPED_INDEX_OOB_COUNT_EN: 3 clamped transactions plus 2 unclamped, one clamped stalled for 5 cycles -> oob_count = 3.
